// File: rtl/l1_dctlb_req_agent.sv
// l1_dctlb_req_agent: L1-side DCTLB translation request initiator.
// Accepts virtual-address lookups from the L1 dcache pipe, tags them through a
// small table, forwards them to the DCTLB and returns physical addresses.
// SPTBR-index recycle commands mark matching in-flight lookups as killed.
// Optional feature: define DCTLB_REQ_TIMEOUT_EN to add a per-entry ack
// watchdog (TIMEOUT cycles) that answers with a fault and parks the entry in
// ZOMBIE until its late ack arrives.
module l1_dctlb_req_agent #(
    parameter int TAG_W   = 2,
    parameter int VA_W    = 39,
    parameter int PPN_W   = 28,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    // lookup channel from the L1 pipe
    input  logic             pipe_req_valid,
    output logic             pipe_req_retry,
    input  logic [VA_W-1:0]  pipe_req_vaddr,
    input  logic [1:0]       pipe_req_sptbr,
    // request channel to the DCTLB
    output logic             req_valid,
    input  logic             req_retry,
    output logic [TAG_W-1:0] req_tag,
    output logic [VA_W-1:0]  req_vaddr,
    output logic [1:0]       req_sptbr,
    // ack channel from the DCTLB
    input  logic             ack_valid,
    output logic             ack_retry,
    input  logic [TAG_W-1:0] ack_tag,
    input  logic [PPN_W-1:0] ack_ppn,
    input  logic             ack_fault,
    // SPTBR index recycle notifications
    input  logic             cmd_valid,
    output logic             cmd_retry,
    input  logic [1:0]       cmd_sptbr,
    // result channel to the L1 pipe
    output logic             resp_valid,
    input  logic             resp_retry,
    output logic [TAG_W-1:0] resp_tag,
    output logic [PPN_W+11:0] resp_paddr,
    output logic             resp_fault,
    output logic             resp_killed,
    // sticky protocol error
    output logic             err_bad_tag
);

    localparam int NTAG = 1 << TAG_W;

    typedef enum logic [1:0] {
        E_FREE   = 2'd0,
        E_QUEUED = 2'd1,
        E_WAIT   = 2'd2
`ifdef DCTLB_REQ_TIMEOUT_EN
        ,
        E_ZOMBIE = 2'd3
`endif
    } entry_state_t;

    entry_state_t     state_q [NTAG];
    entry_state_t     state_d [NTAG];
    logic [11:0]      off_q   [NTAG];
    logic [1:0]       sptbr_q [NTAG];
    logic [NTAG-1:0]  killed_q;

    logic             req_fire;
    logic             ack_fire;
    logic             ack_hit;
    logic             ack_zombie;
    logic             ack_bad;
    logic [NTAG-1:0]  free_vec;
    logic [NTAG-1:0]  kill_vec;
    logic             alloc_found;
    logic [TAG_W-1:0] alloc_idx;
    logic             alloc_fire;
    logic             to_fire;
    logic [TAG_W-1:0] to_idx;

`ifdef DCTLB_REQ_TIMEOUT_EN
    logic [7:0]       cnt_q [NTAG];
    logic             to_found;
`endif

    assign cmd_retry = 1'b0;

    // The resp register has no skid buffer, so acks stall while it is blocked.
    assign ack_retry = resp_valid & resp_retry;
    assign ack_fire  = ack_valid & ~ack_retry;
    assign req_fire  = req_valid & ~req_retry;

    // Classify the incoming ack, find the allocation slot and the kill set.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ack_hit     = ack_fire && (state_q[ack_tag] == E_WAIT);
`ifdef DCTLB_REQ_TIMEOUT_EN
        ack_zombie  = ack_fire && (state_q[ack_tag] == E_ZOMBIE);
`else
        ack_zombie  = 1'b0;
`endif
        ack_bad     = ack_fire && !ack_hit && !ack_zombie;
        free_vec    = '0;
        kill_vec    = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < NTAG; i++) begin
            // an entry freed by this cycle's ack is reusable at the same edge
            free_vec[i] = (state_q[i] == E_FREE) ||
                          ((ack_hit || ack_zombie) && (ack_tag == TAG_W'(i)));
            kill_vec[i] = cmd_valid && (sptbr_q[i] == cmd_sptbr) &&
                          ((state_q[i] == E_QUEUED) || (state_q[i] == E_WAIT)) &&
                          !(ack_hit && (ack_tag == TAG_W'(i)));
        end
        for (int i = NTAG - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = TAG_W'(i);
            end
        end
        pipe_req_retry = !alloc_found || (req_valid && req_retry);
        alloc_fire     = pipe_req_valid && !pipe_req_retry;
    end

`ifdef DCTLB_REQ_TIMEOUT_EN
    // Pick the lowest expired WAIT entry; an ack resp takes the slot first.
    always_comb begin
        to_found = 1'b0;
        to_idx   = '0;
        for (int i = NTAG - 1; i >= 0; i--) begin
            if ((state_q[i] == E_WAIT) && (cnt_q[i] == 8'(TIMEOUT))) begin
                to_found = 1'b1;
                to_idx   = TAG_W'(i);
            end
        end
        to_fire = to_found && !ack_retry && !ack_hit;
    end

    // Watchdog counters run only while an entry waits for its ack.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTAG; i++) begin
            if (!reset || (state_q[i] != E_WAIT)) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] != 8'(TIMEOUT)) begin
                cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_idx  = '0;
`endif

    // Per-entry next state: free is applied before allocation at the same edge.
    always_comb begin
        for (int i = 0; i < NTAG; i++) begin
            state_d[i] = state_q[i];
            if (req_fire && (req_tag == TAG_W'(i))) begin
                state_d[i] = E_WAIT;
            end
            if ((ack_hit || ack_zombie) && (ack_tag == TAG_W'(i))) begin
                state_d[i] = E_FREE;
            end
`ifdef DCTLB_REQ_TIMEOUT_EN
            if (to_fire && (to_idx == TAG_W'(i))) begin
                state_d[i] = E_ZOMBIE;
            end
`endif
            if (alloc_fire && (alloc_idx == TAG_W'(i))) begin
                state_d[i] = E_QUEUED;
            end
        end
    end

    // Entry state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTAG; i++) begin
            if (!reset) begin
                state_q[i] <= E_FREE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Entry payload: captured on allocation, killed bit set by recycle commands.
    // NOTE: payload storage is not reset; it is always written before an entry leaves FREE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTAG; i++) begin
            if (alloc_fire && (alloc_idx == TAG_W'(i))) begin
                off_q[i]    <= pipe_req_vaddr[11:0];
                sptbr_q[i]  <= pipe_req_sptbr;
                killed_q[i] <= cmd_valid && (cmd_sptbr == pipe_req_sptbr);
            end else if (kill_vec[i]) begin
                killed_q[i] <= 1'b1;
            end
        end
    end

    // Request output register toward the DCTLB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_valid <= 1'b0;
            req_tag   <= '0;
            req_vaddr <= '0;
            req_sptbr <= '0;
        end else if (alloc_fire) begin
            req_valid <= 1'b1;
            req_tag   <= alloc_idx;
            req_vaddr <= pipe_req_vaddr;
            req_sptbr <= pipe_req_sptbr;
        end else if (req_fire) begin
            req_valid <= 1'b0;
        end
    end

    // Response output register toward the pipe; ack results beat timeouts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid  <= 1'b0;
            resp_tag    <= '0;
            resp_paddr  <= '0;
            resp_fault  <= 1'b0;
            resp_killed <= 1'b0;
        end else if (ack_hit) begin
            resp_valid  <= 1'b1;
            resp_tag    <= ack_tag;
            resp_paddr  <= {ack_ppn, off_q[ack_tag]};
            resp_fault  <= ack_fault;
            resp_killed <= killed_q[ack_tag];
        end else if (to_fire) begin
            resp_valid  <= 1'b1;
            resp_tag    <= to_idx;
            resp_paddr  <= {{PPN_W{1'b0}}, off_q[to_idx]};
            resp_fault  <= 1'b1;
            resp_killed <= killed_q[to_idx];
        end else if (resp_valid && !resp_retry) begin
            resp_valid  <= 1'b0;
        end
    end

    // Sticky flag for acks naming a tag that is not waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_bad_tag <= 1'b0;
        end else if (ack_bad) begin
            err_bad_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l1_dctlb_req_agent.sv
// tb_l1_dctlb_req_agent: directed self-checking bench for l1_dctlb_req_agent.
// Inputs change 1ns after a rising edge; outputs are sampled there or 1ns later.
// Define DCTLB_REQ_TIMEOUT_EN to also exercise the ack watchdog (TIMEOUT=10).
module tb_l1_dctlb_req_agent;

    localparam int TAG_W = 2;
    localparam int VA_W  = 39;
    localparam int PPN_W = 28;

    logic             clk;
    logic             reset;
    logic             pipe_req_valid;
    logic             pipe_req_retry;
    logic [VA_W-1:0]  pipe_req_vaddr;
    logic [1:0]       pipe_req_sptbr;
    logic             req_valid;
    logic             req_retry;
    logic [TAG_W-1:0] req_tag;
    logic [VA_W-1:0]  req_vaddr;
    logic [1:0]       req_sptbr;
    logic             ack_valid;
    logic             ack_retry;
    logic [TAG_W-1:0] ack_tag;
    logic [PPN_W-1:0] ack_ppn;
    logic             ack_fault;
    logic             cmd_valid;
    logic             cmd_retry;
    logic [1:0]       cmd_sptbr;
    logic             resp_valid;
    logic             resp_retry;
    logic [TAG_W-1:0] resp_tag;
    logic [PPN_W+11:0] resp_paddr;
    logic             resp_fault;
    logic             resp_killed;
    logic             err_bad_tag;

    int total;
    int bad;

    l1_dctlb_req_agent #(
        .TAG_W(TAG_W), .VA_W(VA_W), .PPN_W(PPN_W), .TIMEOUT(10)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_req_valid(pipe_req_valid), .pipe_req_retry(pipe_req_retry),
        .pipe_req_vaddr(pipe_req_vaddr), .pipe_req_sptbr(pipe_req_sptbr),
        .req_valid(req_valid), .req_retry(req_retry), .req_tag(req_tag),
        .req_vaddr(req_vaddr), .req_sptbr(req_sptbr),
        .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_tag(ack_tag),
        .ack_ppn(ack_ppn), .ack_fault(ack_fault),
        .cmd_valid(cmd_valid), .cmd_retry(cmd_retry), .cmd_sptbr(cmd_sptbr),
        .resp_valid(resp_valid), .resp_retry(resp_retry), .resp_tag(resp_tag),
        .resp_paddr(resp_paddr), .resp_fault(resp_fault),
        .resp_killed(resp_killed), .err_bad_tag(err_bad_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_req_valid = 1'b0;
        pipe_req_vaddr = '0;
        pipe_req_sptbr = '0;
        req_retry      = 1'b0;
        ack_valid      = 1'b0;
        ack_tag        = '0;
        ack_ppn        = '0;
        ack_fault      = 1'b0;
        cmd_valid      = 1'b0;
        cmd_sptbr      = '0;
        resp_retry     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h1234;
        step();
        step();
        pipe_req_valid = 1'b0;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (err_bad_tag !== 1'b0) begin bad++; $display("FAIL reset_err_bad_tag: got %b want 0", err_bad_tag); end
        total++; if (req_vaddr !== 39'h0) begin bad++; $display("FAIL reset_req_vaddr: got %h want 0", req_vaddr); end
        total++; if (resp_paddr !== 40'h0) begin bad++; $display("FAIL reset_resp_paddr: got %h want 0", resp_paddr); end
        reset = 1'b1;
        step();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_no_leak: req_valid got %b want 0", req_valid); end
        total++; if (pipe_req_retry !== 1'b0) begin bad++; $display("FAIL reset_pipe_retry: got %b want 0", pipe_req_retry); end
        total++; if (cmd_retry !== 1'b0) begin bad++; $display("FAIL reset_cmd_retry: got %b want 0", cmd_retry); end
    endtask

    task automatic test_single();
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h12345678;
        pipe_req_sptbr = 2'd1;
        #1;
        total++; if (pipe_req_retry !== 1'b0) begin bad++; $display("FAIL single_accept: pipe_req_retry got %b want 0", pipe_req_retry); end
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid: req_valid got %b want 0", req_valid); end
        step();
        pipe_req_valid = 1'b0;
        total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL single_req_valid: got %b want 1", req_valid); end
        total++; if (req_tag !== 2'd0) begin bad++; $display("FAIL single_req_tag: got %0d want 0", req_tag); end
        total++; if (req_vaddr !== 39'h12345678) begin bad++; $display("FAIL single_req_vaddr: got %h want 12345678", req_vaddr); end
        total++; if (req_sptbr !== 2'd1) begin bad++; $display("FAIL single_req_sptbr: got %0d want 1", req_sptbr); end
        step();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL single_req_drop: req_valid got %b want 0", req_valid); end
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        ack_ppn   = 28'hABCDE;
        ack_fault = 1'b0;
        #1;
        total++; if (ack_retry !== 1'b0) begin bad++; $display("FAIL single_ack_retry: got %b want 0", ack_retry); end
        step();
        ack_valid = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_resp_valid: got %b want 1", resp_valid); end
        total++; if (resp_tag !== 2'd0) begin bad++; $display("FAIL single_resp_tag: got %0d want 0", resp_tag); end
        total++; if (resp_paddr !== 40'h00ABCDE678) begin bad++; $display("FAIL single_resp_paddr: got %h want 00abcde678", resp_paddr); end
        total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL single_resp_fault: got %b want 0", resp_fault); end
        total++; if (resp_killed !== 1'b0) begin bad++; $display("FAIL single_resp_killed: got %b want 0", resp_killed); end
        step();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_resp_drop: got %b want 0", resp_valid); end
    endtask

    task automatic test_fill();
        logic [11:0] offs [4] = '{12'h310, 12'h321, 12'h332, 12'h343};
        int          d_tag [4] = '{0, 1, 3, 2};
        logic [11:0] d_off [4] = '{12'h310, 12'h321, 12'h343, 12'h7AA};
        logic        d_flt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            pipe_req_valid = 1'b1;
            pipe_req_vaddr = {27'(i + 7), offs[i]};
            pipe_req_sptbr = 2'd3;
            #1;
            total++; if (pipe_req_retry !== 1'b0) begin bad++; $display("FAIL fill_accept%0d: pipe_req_retry got %b want 0", i, pipe_req_retry); end
            step();
            total++; if (req_tag !== 2'(i)) begin bad++; $display("FAIL fill_tag%0d: got %0d want %0d", i, req_tag, i); end
        end
        pipe_req_vaddr = {27'd9, 12'h7AA};
        #1;
        total++; if (pipe_req_retry !== 1'b1) begin bad++; $display("FAIL fill_full_retry: got %b want 1", pipe_req_retry); end
        step();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL fill_full_noreq: req_valid got %b want 0", req_valid); end
        ack_valid = 1'b1;
        ack_tag   = 2'd2;
        ack_ppn   = 28'h1111;
        #1;
        total++; if (pipe_req_retry !== 1'b0) begin bad++; $display("FAIL fill_free_retry: got %b want 0", pipe_req_retry); end
        step();
        ack_valid = 1'b0;
        pipe_req_valid = 1'b0;
        total++; if (req_tag !== 2'd2 || req_valid !== 1'b1) begin bad++; $display("FAIL fill_realloc: tag %0d valid %b want tag 2 valid 1", req_tag, req_valid); end
        total++; if (resp_valid !== 1'b1 || resp_tag !== 2'd2) begin bad++; $display("FAIL fill_resp2: valid %b tag %0d want 1/2", resp_valid, resp_tag); end
        total++; if (resp_paddr !== {28'h1111, 12'h332}) begin bad++; $display("FAIL fill_resp2_paddr: got %h want %h", resp_paddr, {28'h1111, 12'h332}); end
        for (int i = 0; i < 4; i++) begin
            ack_valid = 1'b1;
            ack_tag   = 2'(d_tag[i]);
            ack_ppn   = 28'(32'h2000 + i);
            ack_fault = d_flt[i];
            step();
            total++; if (resp_valid !== 1'b1 || resp_tag !== 2'(d_tag[i])) begin bad++; $display("FAIL drain_tag%0d: valid %b tag %0d want 1/%0d", i, resp_valid, resp_tag, d_tag[i]); end
            total++; if (resp_paddr !== {28'(32'h2000 + i), d_off[i]} || resp_fault !== d_flt[i]) begin bad++; $display("FAIL drain_data%0d: paddr %h fault %b want %h/%b", i, resp_paddr, resp_fault, {28'(32'h2000 + i), d_off[i]}, d_flt[i]); end
        end
        ack_valid = 1'b0;
        ack_fault = 1'b0;
        step();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL drain_idle: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_back_pressure();
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h7F00000ABC;
        pipe_req_sptbr = 2'd2;
        step();
        pipe_req_vaddr = 39'h55;
        req_retry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (req_valid !== 1'b1 || req_tag !== 2'd0 || req_vaddr !== 39'h7F00000ABC) begin bad++; $display("FAIL bp_hold%0d: valid %b tag %0d vaddr %h want 1/0/7f00000abc", i, req_valid, req_tag, req_vaddr); end
            total++; if (pipe_req_retry !== 1'b1) begin bad++; $display("FAIL bp_pipe_retry%0d: got %b want 1", i, pipe_req_retry); end
            step();
        end
        pipe_req_valid = 1'b0;
        req_retry = 1'b0;
        step();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL bp_release: req_valid got %b want 0", req_valid); end
        resp_retry = 1'b1;
        ack_valid  = 1'b1;
        ack_tag    = 2'd0;
        ack_ppn    = 28'h0FEDC;
        step();
        ack_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (resp_valid !== 1'b1 || resp_paddr !== {28'h0FEDC, 12'hABC}) begin bad++; $display("FAIL bp_resp_hold%0d: valid %b paddr %h want 1/%h", i, resp_valid, resp_paddr, {28'h0FEDC, 12'hABC}); end
            total++; if (ack_retry !== 1'b1) begin bad++; $display("FAIL bp_ack_retry%0d: got %b want 1", i, ack_retry); end
            step();
        end
        resp_retry = 1'b0;
        #1;
        total++; if (ack_retry !== 1'b0) begin bad++; $display("FAIL bp_ack_release: got %b want 0", ack_retry); end
        step();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_resp_drop: got %b want 0", resp_valid); end
    endtask

    task automatic test_kill();
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0A0A;
        pipe_req_sptbr = 2'd0;
        step();
        pipe_req_vaddr = 39'h0B0B;
        pipe_req_sptbr = 2'd1;
        step();
        pipe_req_valid = 1'b0;
        step();
        cmd_valid = 1'b1;
        cmd_sptbr = 2'd0;
        step();
        cmd_valid = 1'b0;
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        ack_ppn   = 28'h1;
        step();
        total++; if (resp_tag !== 2'd0 || resp_killed !== 1'b1) begin bad++; $display("FAIL kill_match: tag %0d killed %b want 0/1", resp_tag, resp_killed); end
        ack_tag = 2'd1;
        ack_ppn = 28'h2;
        step();
        total++; if (resp_tag !== 2'd1 || resp_killed !== 1'b0) begin bad++; $display("FAIL kill_nomatch: tag %0d killed %b want 1/0", resp_tag, resp_killed); end
        ack_valid = 1'b0;
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0C0C;
        pipe_req_sptbr = 2'd0;
        step();
        pipe_req_valid = 1'b0;
        step();
        cmd_valid = 1'b1;
        cmd_sptbr = 2'd0;
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        ack_ppn   = 28'h3;
        step();
        cmd_valid = 1'b0;
        ack_valid = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_killed !== 1'b0) begin bad++; $display("FAIL kill_ack_wins: valid %b killed %b want 1/0", resp_valid, resp_killed); end
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0D0D;
        pipe_req_sptbr = 2'd2;
        cmd_valid = 1'b1;
        cmd_sptbr = 2'd2;
        step();
        pipe_req_valid = 1'b0;
        cmd_valid = 1'b0;
        step();
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        ack_ppn   = 28'h4;
        step();
        ack_valid = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_killed !== 1'b1 || resp_paddr !== {28'h4, 12'hD0D}) begin bad++; $display("FAIL kill_on_alloc: valid %b killed %b paddr %h want 1/1/%h", resp_valid, resp_killed, resp_paddr, {28'h4, 12'hD0D}); end
        step();
    endtask

    task automatic test_bad_tag();
        ack_valid = 1'b1;
        ack_tag   = 2'd3;
        ack_ppn   = 28'h77;
        step();
        ack_valid = 1'b0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bad_tag_noresp: resp_valid got %b want 0", resp_valid); end
        total++; if (err_bad_tag !== 1'b1) begin bad++; $display("FAIL bad_tag_set: got %b want 1", err_bad_tag); end
        step();
        step();
        total++; if (err_bad_tag !== 1'b1) begin bad++; $display("FAIL bad_tag_sticky: got %b want 1", err_bad_tag); end
        do_reset();
        total++; if (err_bad_tag !== 1'b0) begin bad++; $display("FAIL bad_tag_reset: got %b want 0", err_bad_tag); end
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0E0E;
        step();
        pipe_req_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        step();
        ack_valid = 1'b0;
        total++; if (err_bad_tag !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL late_ack_after_reset: err %b resp_valid %b want 1/0", err_bad_tag, resp_valid); end
        do_reset();
    endtask

`ifdef DCTLB_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int seen = -1;
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0DDD;
        pipe_req_sptbr = 2'd3;
        step();
        pipe_req_valid = 1'b0;
        step();
        for (int i = 1; i <= 14; i++) begin
            step();
            if (resp_valid === 1'b1 && seen < 0) begin
                seen = i;
                total++; if (resp_fault !== 1'b1 || resp_tag !== 2'd0) begin bad++; $display("FAIL timeout_resp: fault %b tag %0d want 1/0", resp_fault, resp_tag); end
            end
        end
        total++; if (seen < 10 || seen > 11) begin bad++; $display("FAIL timeout_latency: got %0d want 10..11 cycles", seen); end
        pipe_req_valid = 1'b1;
        pipe_req_vaddr = 39'h0EEE;
        step();
        pipe_req_valid = 1'b0;
        total++; if (req_tag !== 2'd1) begin bad++; $display("FAIL timeout_zombie_skip: tag %0d want 1", req_tag); end
        step();
        ack_valid = 1'b1;
        ack_tag   = 2'd0;
        step();
        ack_valid = 1'b0;
        total++; if (resp_valid !== 1'b0 || err_bad_tag !== 1'b0) begin bad++; $display("FAIL timeout_late_ack: resp_valid %b err %b want 0/0", resp_valid, err_bad_tag); end
        pipe_req_valid = 1'b1;
        step();
        pipe_req_valid = 1'b0;
        total++; if (req_tag !== 2'd0) begin bad++; $display("FAIL timeout_realloc: tag %0d want 0", req_tag); end
        do_reset();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_fill();
        test_back_pressure();
        test_kill();
        test_bad_tag();
`ifdef DCTLB_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_dctlb_req_agent.md
Name: l1_dctlb_req_agent

Overview:
- L1-side initiator for the DCTLB translation protocol.
- Accepts virtual-address lookups from the L1 dcache pipe and issues tagged requests to the DCTLB on a valid/retry channel.
- Tracks outstanding requests in a small tag table, matches DCTLB acks by tag, and returns physical addresses to the pipe.
- Consumes the DCTLB's SPTBR-index invalidation notifications and marks in-flight lookups on a recycled index as killed.

Parameters:
- TAG_W, 2, tag width; table depth NTAG = 2**TAG_W.
- VA_W, 39, virtual address width.
- PPN_W, 28, physical page number width; paddr width PA_W = PPN_W+12.
- TIMEOUT, 255, ack watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- pipe_req_valid  in  1  lookup request from L1 pipe.
- pipe_req_retry  out  1  back-pressure to pipe.
- pipe_req_vaddr  in  VA_W  virtual address.
- pipe_req_sptbr  in  2  SPTBR checkpoint index.
- req_valid  out  1  request to DCTLB.
- req_retry  in  1  DCTLB back-pressure.
- req_tag  out  TAG_W  allocated tag.
- req_vaddr  out  VA_W  forwarded vaddr.
- req_sptbr  out  2  forwarded index.
- ack_valid  in  1  DCTLB ack.
- ack_retry  out  1  back-pressure to DCTLB.
- ack_tag  in  TAG_W  tag being acked.
- ack_ppn  in  PPN_W  translated page.
- ack_fault  in  1  translation fault.
- cmd_valid  in  1  SPTBR index recycled notification.
- cmd_retry  out  1  tied 0; commands are always accepted.
- cmd_sptbr  in  2  recycled index.
- resp_valid  out  1  result to pipe.
- resp_retry  in  1  pipe back-pressure.
- resp_tag  out  TAG_W  tag of result.
- resp_paddr  out  PA_W  {ppn, vaddr[11:0]}.
- resp_fault  out  1  fault from DCTLB, or timeout.
- resp_killed  out  1  index was recycled while in flight.
- err_bad_tag  out  1  sticky: ack for a tag not in WAIT.

Behaviour:
- Handshake rule, all channels: a transfer occurs on a cycle with valid=1 and retry=0. The sender holds valid and payload stable while retry=1.
- Reset (reset=0 at a clk edge):
  - All entries go to FREE.
  - req_valid, resp_valid, err_bad_tag = 0; payload outputs = 0.
  - Reset mid-transaction drops all state; late acks after reset set err_bad_tag.
- Per-entry state machine: FREE -> QUEUED -> WAIT -> FREE. Each entry stores vaddr[11:0], sptbr and a killed bit.
- Allocation:
  - pipe_req_retry = 1 when no FREE entry exists, or when the req output register holds a request and req_retry=1.
  - On accept, the lowest-index FREE entry becomes QUEUED, and the req register loads at the same edge. req_valid rises the next cycle (1-cycle latency).
  - The entry moves QUEUED -> WAIT when req transfers.
- Ack:
  - ack_retry = resp_valid & resp_retry. resp is a single output register with no skid buffer.
  - An accepted ack on a WAIT entry loads resp the next cycle: paddr = {ack_ppn, stored offset}, fault = ack_fault, killed = entry.killed. The entry is freed at the same edge.
  - An accepted ack on a non-WAIT tag: err_bad_tag sets, the ack is dropped, and no resp is produced.
- Cmd:
  - Every QUEUED or WAIT entry with sptbr == cmd_sptbr gets killed = 1.
  - An entry allocated at the same edge with a matching sptbr also gets killed = 1.
  - An entry acked at the same edge is not killed; the ack wins.
- A freed entry may be reallocated at the same edge it frees; the free is applied before allocation.
- Full table: the pipe stalls until an ack frees an entry; there is no ordering among responses.

Optional Feature:
- Macro: DCTLB_REQ_TIMEOUT_EN.
- Defined:
  - Each WAIT entry has an 8-bit counter, cleared on entering WAIT.
  - When the counter reaches TIMEOUT, a resp is produced with fault=1, and the entry moves to ZOMBIE. It stays unallocatable until its late ack arrives; that ack is dropped silently, without err_bad_tag, and the entry is freed.
  - A timeout resp has lower priority than an ack resp; it retries on the following cycle.
- Undefined: no counters and no ZOMBIE state; entries wait indefinitely.

Test Plan:
- Single lookup: vaddr=0x12345678, sptbr=1, ack ppn=0xABCDE at tag 0 -> resp_paddr=0xABCDE678, fault=0, killed=0; req_valid one cycle after accept.
- Fill: 4 accepted with no acks -> 5th sees pipe_req_retry=1. Ack tag 2 -> the next request gets tag 2.
- Back-pressure: req_retry=1 for 3 cycles -> req_tag/vaddr stable. Then resp_retry=1 with resp pending -> ack_retry=1 and resp held.
- Kill: requests on sptbr 0 and 1 outstanding, cmd_sptbr=0 -> sptbr0 resp has killed=1, sptbr1 resp has killed=0. Cmd on the same cycle as the ack of the sptbr0 entry -> killed=0.
- Bad tag: ack tag 3 while entry 3 is FREE -> no resp, err_bad_tag=1 until reset.
- Timeout (macro defined, TIMEOUT=10): no ack -> resp fault=1 after 10 WAIT cycles. A later ack for the same tag is dropped, and the entry becomes allocatable.
